// File: rtl/core_pkg.sv
// Shared core parameters: reservation-station sizing, the entry-index type and the issue counter limit.
package CORE_PKG;

    localparam int RS_ENTRIES = 8;

    typedef logic [$clog2(RS_ENTRIES)-1:0] rs_idx_t;

    localparam logic [31:0] ISSUED_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/issue_select_age_matrix.sv
// Oldest-first selector for issue_select (used only when ISSUE_SELECT_AGE_EN is defined).
// r_older[i][j]=1 means entry i was dispatched before entry j.
module age_matrix #(
    parameter int RS_ENTRIES = CORE_PKG::RS_ENTRIES,
    parameter int ENTRY_W    = $clog2(RS_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_disp_valid,
    input  logic [ENTRY_W-1:0]    i_disp_entry,
    input  logic [RS_ENTRIES-1:0] i_reqs,
    output logic [ENTRY_W-1:0]    o_sel
);

    logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] r_older;
    logic                                  w_found;
    logic                                  w_blocked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_older <= '0;
        end else if (i_clr) begin
            r_older <= '0;
        end else if (i_disp_valid) begin
            // The new entry becomes the youngest: everyone is older than it, it is older than no one.
            for (int i = 0; i < RS_ENTRIES; i++) begin
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    if (ENTRY_W'(i) == i_disp_entry) begin
                        r_older[i][j] <= 1'b0;
                    end else if (ENTRY_W'(j) == i_disp_entry) begin
                        r_older[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        o_sel     = '0;
        w_found   = 1'b0;
        w_blocked = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_blocked = 1'b0;
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (i_reqs[j] && r_older[j][i]) begin
                    w_blocked = 1'b1;
                end
            end
            if (!w_found && i_reqs[i] && !w_blocked) begin
                w_found = 1'b1;
                o_sel   = ENTRY_W'(i);
            end
        end
    end

endmodule

// File: rtl/issue_select.sv
// Reservation-station issue selector with a one-deep registered issue slot.
// Round-robin by default; define ISSUE_SELECT_AGE_EN for oldest-first selection.
module issue_select #(
    parameter int RS_ENTRIES = CORE_PKG::RS_ENTRIES,
    parameter int ENTRY_W    = $clog2(RS_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  disp_valid,
    input  logic [ENTRY_W-1:0]    disp_entry,
    input  logic [RS_ENTRIES-1:0] reqs,
    output logic [RS_ENTRIES-1:0] grant,
    output logic                  grant_valid,
    output logic                  iss_valid,
    output logic [ENTRY_W-1:0]    iss_entry,
    input  logic                  fu_ready,
    input  logic                  flush,
    output logic [31:0]           issued_count
);

    logic               r_iss_valid;
    logic [ENTRY_W-1:0] r_iss_entry;
    logic [31:0]        r_issued_count;
    logic               w_slot_free;
    logic               w_grant_valid;
    logic [ENTRY_W-1:0] w_sel;

    // Handshake: the slot transfers to the FU on any cycle with iss_valid && fu_ready; while
    // iss_valid && !fu_ready the slot holds and no new grant is made.
    assign w_slot_free   = !r_iss_valid || fu_ready;
    assign w_grant_valid = (|reqs) && w_slot_free && !flush;

`ifdef ISSUE_SELECT_AGE_EN
    age_matrix #(
        .RS_ENTRIES (RS_ENTRIES),
        .ENTRY_W    (ENTRY_W)
    ) u_age_matrix (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (flush),
        .i_disp_valid (disp_valid),
        .i_disp_entry (disp_entry),
        .i_reqs       (reqs),
        .o_sel        (w_sel)
    );
`else
    logic [ENTRY_W-1:0] r_rr_ptr;
    logic [ENTRY_W:0]   w_idx;
    logic               w_found;
    logic               w_unused_disp;

    assign w_unused_disp = disp_valid ^ (^disp_entry);

    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < RS_ENTRIES; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (ENTRY_W+1)'(k);
            if (w_idx >= (ENTRY_W+1)'(RS_ENTRIES)) begin
                w_idx = w_idx - (ENTRY_W+1)'(RS_ENTRIES);
            end
            if (!w_found && reqs[w_idx[ENTRY_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[ENTRY_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (flush) begin
            r_rr_ptr <= '0;
        end else if (w_grant_valid) begin
            r_rr_ptr <= (w_sel == ENTRY_W'(RS_ENTRIES-1)) ? '0 : w_sel + 1'b1;
        end
    end
`endif

    always_comb begin
        grant = '0;
        if (w_grant_valid) begin
            grant[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_valid    <= 1'b0;
            r_iss_entry    <= '0;
            r_issued_count <= '0;
        end else begin
            if (r_iss_valid && fu_ready && !flush && (r_issued_count != CORE_PKG::ISSUED_MAX)) begin
                r_issued_count <= r_issued_count + 32'd1;
            end
            if (flush) begin
                r_iss_valid <= 1'b0;
            end else if (w_grant_valid) begin
                r_iss_valid <= 1'b1;
                r_iss_entry <= w_sel;
            end else if (fu_ready) begin
                r_iss_valid <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    // Dispatching into an entry that is still requesting would corrupt its age/issue state.
    a_disp_to_requesting : assert property (@(posedge clk) disable iff (rst)
        !(disp_valid && reqs[disp_entry]));
`endif

    assign grant_valid  = w_grant_valid;
    assign iss_valid    = r_iss_valid;
    assign iss_entry    = r_iss_entry;
    assign issued_count = r_issued_count;

endmodule

// File: doc/issue_select.md
ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 Parameter: RS_ENTRIES, default CORE_PKG::RS_ENTRIES (8), number of reservation-station entries arbitrated.
REQ-002 Parameter: ENTRY_W, default $clog2(RS_ENTRIES), entry index width.
REQ-003 Port: clk  in  1  single clock; all state on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: disp_valid  in  1  an entry is being written by dispatch this cycle.
REQ-006 Port: disp_entry  in  ENTRY_W  index written, driven from wakeup free_entry_out.
REQ-007 Port: reqs  in  RS_ENTRIES  per-entry ready-to-issue requests from wakeup.
REQ-008 Port: grant  out  RS_ENTRIES  one-hot grant back to wakeup, combinational.
REQ-009 Port: grant_valid  out  1  grant holds a valid selection this cycle.
REQ-010 Port: iss_valid  out  1  registered issue slot holds an instruction for the FU.
REQ-011 Port: iss_entry  out  ENTRY_W  RS entry index in the issue slot.
REQ-012 Port: fu_ready  in  1  FU accepts the issue slot this cycle.
REQ-013 Port: flush  in  1  pipeline flush (mispredict/exception).
REQ-014 Port: issued_count  out  32  count of instructions accepted by the FU.

Function
REQ-015 Slot free when !iss_valid || fu_ready; grant_valid = |reqs && slot free && !flush.
REQ-016 grant SHALL be all-zero when grant_valid is 0, else exactly one bit set, that bit also set in reqs.
REQ-017 Latency: grant in cycle N -> iss_valid=1, iss_entry=granted index in cycle N+1.
REQ-018 iss_valid && !fu_ready: iss_valid, iss_entry held unchanged, grant_valid=0.
REQ-019 iss_valid && fu_ready && no grant: iss_valid clears next cycle.
REQ-020 iss_valid && fu_ready && grant in same cycle: slot reloads with new entry, no bubble.
REQ-021 issued_count increments when iss_valid && fu_ready && !flush; saturates at 0xFFFF_FFFF.
REQ-022 flush: iss_valid cleared next cycle, grant_valid forced 0 that cycle, selection state cleared as at reset; issued_count not cleared.
REQ-023 Selection policy is defined under Configuration; both policies obey REQ-015..REQ-020.
REQ-024 disp_valid to an entry whose reqs bit is set is illegal; behaviour undefined, flagged by simulation assertion.

Reset
REQ-025 During rst: iss_valid=0, iss_entry=0, issued_count=0, age matrix all 0, rr_ptr=0; grant/grant_valid follow reqs combinationally but issue register does not load.
REQ-026 rst asserted mid-stall (iss_valid=1, fu_ready=0) SHALL clear the slot immediately, without waiting for a clock edge.

Configuration
REQ-027 Macro ISSUE_SELECT_AGE_EN defined: oldest-first via RS_ENTRIES x RS_ENTRIES age matrix; older[i][j]=1 means i older than j.
REQ-028 With ISSUE_SELECT_AGE_EN, on disp_valid to k: older[i][k]<=1 for all i!=k, older[k][*]<=0; winner is the requesting i with no requesting j where older[j][i]=1; ties (all-zero matrix) resolve to lowest index.
REQ-029 Macro undefined: round-robin; search from rr_ptr upward with wrap, first requester wins; on grant of i, rr_ptr<=(i+1) mod RS_ENTRIES; disp inputs ignored.

Structure
REQ-030 RS_ENTRIES and an entry-index typedef (rs_idx_t) SHALL live in CORE_PKG; no new package.
REQ-031 One sub-module: age_matrix (update and oldest-select), instantiated only under ISSUE_SELECT_AGE_EN.

Verification (RS_ENTRIES=8)
REQ-032 Single req: reqs=8'b0000_0100, fu_ready=1 -> grant=8'b0000_0100, grant_valid=1; next cycle iss_valid=1, iss_entry=2.
REQ-033 Stall: iss_valid=1, fu_ready=0 for 3 cycles, reqs=8'hFF -> grant_valid=0, iss_entry unchanged 3 cycles; fu_ready=1 -> back-to-back reload, no bubble.
REQ-034 AGE_EN: dispatch entries 5, 1, 3 in order, reqs=8'b0010_1010 -> grants 5, then 1, then 3 (requests dropped as granted).
REQ-035 RR: reqs=8'hFF held, fu_ready=1 -> grants 0,1,...,7,0 on consecutive cycles (wrap-around).
REQ-036 Flush: iss_valid=1, flush=1 with reqs=8'h01 -> grant_valid=0 that cycle, iss_valid=0 next, issued_count unchanged.
REQ-037 Async reset: assert rst between edges while iss_valid=1 -> iss_valid=0 before next edge; issued_count=0.
